seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
Parametrised multi-digit, time-multiplexed seven-segment controller. It is the successor to the fixed 4-digit display driver and sits beside the computer core, showing the output register value. Adds selectable hex or unsigned-decimal rendering (sequential double-dabble), a configurable digit count and width, and overflow indication. Display contents update atomically, so digits never tear mid-conversion.

Parameters:
DATA_WIDTH, 8, width of the value to display (1..32)
NUM_DIGITS, 4, number of physical digits (1..8)
SCAN_DIV, 20000, clk cycles each digit stays selected (>=1; 20 MHz / 20000 = 1 kHz digit rate)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
number  input  DATA_WIDTH  unsigned value to display
mode_dec  input  1  0 = hexadecimal, 1 = unsigned decimal
seg7  output  7  segments, active-low; bit0 = a ... bit6 = g
select  output  NUM_DIGITS  digit enables, active-low; bit0 = rightmost digit
busy  output  1  high while a decimal conversion is in progress

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and reset.
- Reset values:
  - seg7 = all 1s (blank); select = all 1s (none selected); busy = 0.
  - Prescaler = 0, digit index = 0, display digit register = all zeros.
  - Converter FSM = IDLE.
- Reset mid-conversion aborts the conversion. The display register is not updated from the aborted run.
- Converter FSM states: IDLE, SHIFT, LOAD.
  - IDLE: capture number and mode_dec every cycle.
    - Hex: go to LOAD.
    - Decimal: clear the BCD accumulator, set the bit counter to DATA_WIDTH, assert busy, go to SHIFT.
  - SHIFT: one iteration per cycle. Add 3 to every BCD nibble >= 5, then shift left one bit, taking in the captured MSB first. Decrement the counter; at 0 go to LOAD.
  - LOAD: write all digits to the display register in a single cycle, deassert busy, go to IDLE.
- Latency from number sample to display register update:
  - Hex: 2 cycles.
  - Decimal: DATA_WIDTH + 2 cycles.
- Conversion runs continuously. Input changes during SHIFT are ignored until the next IDLE.
- BCD accumulator width: 4*ceil(DATA_WIDTH*0.302+1) digits, computed at elaboration.
- Overflow: value needs more than NUM_DIGITS digits in the active mode.
  - Example: DATA_WIDTH=16, mode_dec=1, value 10000 on 4 digits.
  - Every digit shows '-' (segment g only, seg7 = 7'h3F).
  - Hex overflow is a static condition: DATA_WIDTH > 4*NUM_DIGITS, with any nonzero bit above 4*NUM_DIGITS.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it wraps to 0 and the digit index advances.
  - Digit index wraps NUM_DIGITS-1 -> 0.
- Outputs are registered. seg7 and select change in the same cycle, so a segment pattern never appears on the wrong digit.
- Exactly one select bit is low at any time after the first post-reset cycle.
- Encoding (active-low):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
  - A=08 b=03 C=46 d=21 E=06 F=0E; '-'=3F; blank=7F
- A display register update mid-scan takes effect on the next registered output cycle. It does not reset the scan.

Optional Feature:
Macro SEG7_ZERO_BLANK_EN.
- Defined: leading zero digits above the most significant nonzero digit show blank (7'h7F), in both modes. Digit 0 always shows its value, so zero displays as a single '0'. Overflow dashes are unaffected.
- Undefined: all digits are shown, including leading zeros.

Test Plan:
1. Reset held 3 cycles, then released with number=0, mode_dec=0, SCAN_DIV=4, NUM_DIGITS=4 -> during reset seg7=7F, select=F. After release, select cycles E,D,B,7 every 4 cycles with seg7=40 on each digit.
2. number=8'hAF, mode_dec=0 -> within 2 cycles, digit0 seg7=0E, digit1=08, digits2-3=40.
3. number=8'd255, mode_dec=1 -> busy high for exactly 8 cycles, then digits show 0,2,5,5 (40,24,12,12). With SEG7_ZERO_BLANK_EN, digit3=7F.
4. DATA_WIDTH=16, number=16'd10000, mode_dec=1 -> all four digits show 3F. Then number=16'd9999 -> digits 10,10,10,10.
5. Reset asserted mid-SHIFT (cycle 4 of 8) -> busy=0 and the display register is zero next cycle. No partial value is ever displayed.
6. number toggled 8'd12 <-> 8'd34 every cycle in decimal mode -> every displayed frame is exactly 12 or 34, never a mix of digits.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment controller with hex or sequential double-dabble decimal rendering.
// Optional macro SEG7_ZERO_BLANK_EN blanks leading zero digits above the most significant nonzero digit.
module seg7_scan_display #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 20000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] number,
    input  logic                  mode_dec,
    output logic [6:0]            seg7,
    output logic [NUM_DIGITS-1:0] select,
    output logic                  busy
);
    localparam int BCD_DIGITS = (DATA_WIDTH * 302 + 1999) / 1000;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int SRC_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int SRC_W      = 4 * SRC_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] num_q;
    logic                  dec_q;
    logic [BCD_W-1:0]      bcd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DISP_W-1:0]     disp_q;
    logic                  ovf_q;
    logic [PRE_W-1:0]      pre_q;
    logic [IDX_W-1:0]      idx_q;

    logic [BCD_W-1:0]      adj;
    logic [SRC_W-1:0]      src;
    logic [3:0]            cur;
    logic [NUM_DIGITS-1:0] sel_next;
    logic [6:0]            seg_next;

    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign adj = dabble(bcd_q);

    // Whichever rendering is active, widened so digits beyond the display can flag overflow.
    always_comb begin
        src = '0;
        if (dec_q) src[BCD_W-1:0] = bcd_q;
        else       src[DATA_WIDTH-1:0] = num_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            num_q  <= '0;
            dec_q  <= 1'b0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    num_q <= number;
                    dec_q <= mode_dec;
                    if (mode_dec) begin
                        bcd_q <= '0;
                        cnt_q <= CNT_W'(DATA_WIDTH);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= LOAD;
                    end
                end
                SHIFT: begin
                    // The adjusted top bit is always zero, so the truncation drops nothing.
                    bcd_q <= BCD_W'({adj, num_q[DATA_WIDTH-1]});
                    num_q <= num_q << 1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    disp_q <= src[DISP_W-1:0];
                    ovf_q  <= |(src >> DISP_W);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEG7_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead;
    logic                  zero_above;
    logic                  lead_cur;

    always_comb begin
        lead       = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_q[4*i +: 4] == 4'h0);
            lead[i]    = zero_above;
        end
    end
`endif

    always_comb begin
        cur      = 4'h0;
        sel_next = '1;
`ifdef SEG7_ZERO_BLANK_EN
        lead_cur = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur         = disp_q[4*i +: 4];
                sel_next[i] = 1'b0;
`ifdef SEG7_ZERO_BLANK_EN
                lead_cur    = lead[i];
`endif
            end
        end
    end

    always_comb begin
        if (ovf_q)         seg_next = 7'h3F;
`ifdef SEG7_ZERO_BLANK_EN
        else if (lead_cur) seg_next = 7'h7F;
`endif
        else               seg_next = enc(cur);
    end

    // Segments and select come from the same digit index in the same register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            idx_q  <= '0;
            seg7   <= 7'h7F;
            select <= '1;
        end else begin
            if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            seg7   <= seg_next;
            select <= sel_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: 8-bit and 16-bit instances, scan divider 4, four digits.
module tb_seg7_scan_display;
    localparam int SCAN = 4;
`ifdef SEG7_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif
    localparam logic [27:0] F12 = {LZ, LZ, 7'h79, 7'h24};
    localparam logic [27:0] F34 = {LZ, LZ, 7'h30, 7'h19};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  num8 = '0;
    logic        dec8 = 1'b0;
    logic [6:0]  seg8;
    logic [3:0]  sel8;
    logic        busy8;
    logic [15:0] num16 = '0;
    logic        dec16 = 1'b0;
    logic [6:0]  seg16;
    logic [3:0]  sel16;
    logic        busy16;
    logic        use16 = 1'b0;
    logic [6:0]  mon_seg;
    logic [3:0]  mon_sel;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.DATA_WIDTH(8), .NUM_DIGITS(4), .SCAN_DIV(SCAN)) u_dut8 (
        .clk(clk), .reset(reset), .number(num8), .mode_dec(dec8),
        .seg7(seg8), .select(sel8), .busy(busy8)
    );

    seg7_scan_display #(.DATA_WIDTH(16), .NUM_DIGITS(4), .SCAN_DIV(SCAN)) u_dut16 (
        .clk(clk), .reset(reset), .number(num16), .mode_dec(dec16),
        .seg7(seg16), .select(sel16), .busy(busy16)
    );

    assign mon_seg = use16 ? seg16 : seg8;
    assign mon_sel = use16 ? sel16 : sel8;

    // Monitor: each new digit presented from a frame start (select E) pops one expectation.
    logic [3:0]  prev_sel = 4'hF;
    int          frame_pos = -1;
    int          dwell = 0;
    logic [10:0] got;
    logic [10:0] want;
    string       nm;

    always @(negedge clk) begin
        dwell++;
        if (mon_sel !== prev_sel) begin
            if (exp_q.size() == 0) begin
                frame_pos = -1;
            end else begin
                if (frame_pos < 0 && mon_sel === 4'hE) frame_pos = 0;
                if (frame_pos >= 0) begin
                    want = exp_q.pop_front();
                    nm   = name_q.pop_front();
                    got  = {mon_sel, mon_seg};
                    n_vec++;
                    if (got !== want) begin
                        n_miss++;
                        $display("FAIL %s: got sel=%h seg=%h, want sel=%h seg=%h",
                                 nm, got[10:7], got[6:0], want[10:7], want[6:0]);
                    end
                    if (prev_sel !== 4'hF) begin
                        n_vec++;
                        if (dwell != SCAN) begin
                            n_miss++;
                            $display("FAIL %s_dwell: got %0d cycles, want %0d", nm, dwell, SCAN);
                        end
                    end
                    frame_pos = (frame_pos == 3) ? -1 : frame_pos + 1;
                end
            end
            dwell = 0;
        end
        prev_sel = mon_sel;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input string name, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
        exp_q.push_back({4'hE, d0}); name_q.push_back({name, "_d0"});
        exp_q.push_back({4'hD, d1}); name_q.push_back({name, "_d1"});
        exp_q.push_back({4'hB, d2}); name_q.push_back({name, "_d2"});
        exp_q.push_back({4'h7, d3}); name_q.push_back({name, "_d3"});
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got %0d digits unseen, want 0", name, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic measure_busy(output int width);
        int t = 0;
        width = 0;
        while (busy8 === 1'b1 && t < 100) begin @(negedge clk); t++; end
        while (busy8 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        while (busy8 === 1'b1 && width < 100) begin @(negedge clk); width++; end
    endtask

    task automatic capture_frame(output logic [27:0] fr, output logic found);
        int t = 0;
        fr = '0;
        found = 1'b0;
        while (sel8 === 4'hE && t < 40) begin @(negedge clk); t++; end
        while (sel8 !== 4'hE && t < 40) begin @(negedge clk); t++; end
        if (sel8 === 4'hE) begin
            found = 1'b1;
            for (int k = 0; k < 4; k++) begin
                fr[7*k +: 7] = seg8;
                repeat (SCAN) @(negedge clk);
            end
        end
    endtask

    initial begin
        int          w;
        logic [27:0] fr;
        logic        found;

        // Reset held three cycles.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_seg8", 32'(seg8), 32'h7F);
            check("rst_sel8", 32'(sel8), 32'hF);
            check("rst_busy8", 32'(busy8), 32'h0);
        end
        check("rst_seg16", 32'(seg16), 32'h7F);
        check("rst_sel16", 32'(sel16), 32'hF);

        push_frame("zero_hex", LZ, LZ, LZ, 7'h40);
        reset = 1'b0;
        wait_drain("zero_hex");

        num8 = 8'hAF;
        dec8 = 1'b0;
        repeat (10) @(negedge clk);
        push_frame("hex_af", LZ, LZ, 7'h08, 7'h0E);
        wait_drain("hex_af");

        num8 = 8'd255;
        dec8 = 1'b1;
        measure_busy(w);
        check("busy_width", 32'(w), 32'd8);
        repeat (4) @(negedge clk);
        push_frame("dec_255", LZ, 7'h24, 7'h12, 7'h12);
        wait_drain("dec_255");

        use16 = 1'b1;
        num16 = 16'd10000;
        dec16 = 1'b1;
        repeat (40) @(negedge clk);
        push_frame("ovf_10000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        wait_drain("ovf_10000");
        num16 = 16'd9999;
        repeat (40) @(negedge clk);
        push_frame("dec_9999", 7'h10, 7'h10, 7'h10, 7'h10);
        wait_drain("dec_9999");
        num16 = 16'h1234;
        dec16 = 1'b0;
        repeat (40) @(negedge clk);
        push_frame("hex_1234", 7'h79, 7'h24, 7'h30, 7'h19);
        wait_drain("hex_1234");
        num16 = 16'd0;
        dec16 = 1'b1;
        repeat (40) @(negedge clk);
        push_frame("dec_zero16", LZ, LZ, LZ, 7'h40);
        wait_drain("dec_zero16");
        use16 = 1'b0;

        // Abort a conversion four cycles into its shift phase.
        num8 = 8'd99;
        dec8 = 1'b1;
        w = 0;
        while (busy8 === 1'b1 && w < 50) begin @(negedge clk); w++; end
        while (busy8 !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy8), 32'h0);
        check("abort_seg", 32'(seg8), 32'h7F);
        check("abort_sel", 32'(sel8), 32'hF);
        reset = 1'b0;
        @(negedge clk);
        check("abort_disp_cleared", 32'(seg8), 32'h40);
        check("abort_first_sel", 32'(sel8), 32'hE);
        repeat (30) @(negedge clk);
        push_frame("dec_99", LZ, LZ, 7'h10, 7'h10);
        wait_drain("dec_99");

        // Inputs toggling every cycle must still yield whole frames.
        num8 = 8'd12;
        fork
            begin
                repeat (150) begin
                    @(negedge clk);
                    num8 = (num8 == 8'd12) ? 8'd34 : 8'd12;
                end
            end
            begin
                repeat (30) @(negedge clk);
                for (int f = 0; f < 4; f++) begin
                    capture_frame(fr, found);
                    n_vec++;
                    if (!found || (fr !== F12 && fr !== F34)) begin
                        n_miss++;
                        $display("FAIL toggle_frame%0d: got %h, want %h or %h", f, fr, F12, F34);
                    end
                end
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        n_miss++;
        $display("FAIL watchdog: got time %0t, want completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
